// File: rtl/forward_scoreboard_if.sv
// Issue, source-read and bypass-select bundle between decode and the forwarding scoreboard.
interface forward_scoreboard_if #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned DEPTH = 5
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned AW = $clog2(DEPTH + 1);

  logic              ADVANCE;
  logic              FLUSH;
  logic              ISSUE_VALID;
  logic [RW-1:0]     ISSUE_RD;
  logic [1:0]        ISSUE_TYPE;
  logic [NRD*RW-1:0] RS_SEL;
  logic [NRD*AW-1:0] FWD_SEL;
  logic [NRD*2-1:0]  RS_TYPE;
  logic              STALL;
  logic              ISSUE_ACK;

  // Decode side: drives issue/read requests, receives bypass selects.
  modport master (
    output ADVANCE, FLUSH, ISSUE_VALID, ISSUE_RD, ISSUE_TYPE, RS_SEL,
    input  FWD_SEL, RS_TYPE, STALL, ISSUE_ACK
  );

  // Scoreboard side.
  modport slave (
    input  ADVANCE, FLUSH, ISSUE_VALID, ISSUE_RD, ISSUE_TYPE, RS_SEL,
    output FWD_SEL, RS_TYPE, STALL, ISSUE_ACK
  );
endinterface

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks the youngest in-flight producer of each
// architectural register and tells decode which bypass stage to read or
// whether it must stall. Reads are combinational from current state so an
// entry written at one edge is visible in the very next cycle.
module forward_scoreboard #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned NRD       = 2,
  parameter int unsigned DEPTH     = 5,
  parameter int unsigned ALU_RDY   = 1,
  parameter int unsigned LD_RDY    = 2,
  parameter int unsigned FLUSH_AGE = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  forward_scoreboard_if.slave  bus
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned AW = $clog2(DEPTH + 1);

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_ALU  = 2'd1;
  localparam logic [1:0] CLS_LD   = 2'd2;

  // Reject parameter sets where readiness or flush ages fall outside the pipe.
  if (ALU_RDY < 1 || ALU_RDY > LD_RDY || LD_RDY > DEPTH ||
      FLUSH_AGE >= DEPTH || NREG < 2 || NRD < 1) begin : g_param_check
    $error("forward_scoreboard: illegal parameter set");
  end

  typedef struct packed {
    logic          valid;
    logic [1:0]    cls;
    logic [AW-1:0] age;
  } entry_t;

  entry_t ent_q [NREG];
  entry_t ent_d [NREG];

  logic              rd_busy_c;
  logic [NRD*AW-1:0] fwd_c;
  logic [NRD*2-1:0]  typ_c;
  logic              stall_c;
  logic              issue_acc_c;
  logic              issue_is_op_c;
  logic [RW-1:0]     rd_rs;
  entry_t            rd_ent;
  logic              rd_ready;

  // Per-port lookup: producer class, bypass age and readiness.
  always_comb begin
    rd_busy_c = 1'b0;
    fwd_c     = '0;
    typ_c     = '0;
    rd_rs     = '0;
    rd_ent    = '0;
    rd_ready  = 1'b1;
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_rs  = bus.RS_SEL[p*RW +: RW];
      rd_ent = '0;
      if (rd_rs != '0 && int'(rd_rs) < int'(NREG)) begin
        rd_ent = ent_q[rd_rs];
      end
      rd_ready = !rd_ent.valid ||
                 (rd_ent.cls == CLS_ALU && rd_ent.age >= AW'(ALU_RDY)) ||
                 (rd_ent.cls == CLS_LD  && rd_ent.age >= AW'(LD_RDY));
      if (rd_ent.valid) begin
        typ_c[p*2 +: 2] = rd_ent.cls;
        if (rd_ready) begin
          fwd_c[p*AW +: AW] = rd_ent.age;
        end
      end
      if (!rd_ready) begin
        rd_busy_c = 1'b1;
      end
    end
  end

  assign stall_c       = (rd_busy_c && !RST) || !bus.ADVANCE;
  assign issue_is_op_c = (bus.ISSUE_TYPE == CLS_ALU) || (bus.ISSUE_TYPE == CLS_LD);
  assign issue_acc_c   = bus.ISSUE_VALID && bus.ADVANCE && !stall_c &&
                         !bus.FLUSH && issue_is_op_c && !RST;

  assign bus.FWD_SEL   = RST ? '0 : fwd_c;
  assign bus.RS_TYPE   = RST ? '0 : typ_c;
  assign bus.STALL     = stall_c;
  assign bus.ISSUE_ACK = issue_acc_c;

  // Next entry state: flush kill, then new issue, then aging/retirement.
  always_comb begin
    ent_d    = ent_q;
    ent_d[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (bus.FLUSH && ent_q[r].valid && ent_q[r].age <= AW'(FLUSH_AGE)) begin
        ent_d[r] = '0;
      end else if (issue_acc_c && bus.ISSUE_RD == RW'(r)) begin
        ent_d[r] = '{valid: 1'b1, cls: bus.ISSUE_TYPE, age: AW'(1)};
      end else if (bus.ADVANCE && ent_q[r].valid) begin
        if (ent_q[r].age == AW'(DEPTH)) begin
          ent_d[r] = '0;
        end else begin
          ent_d[r].age = ent_q[r].age + AW'(1);
        end
      end
    end
  end

  // Entry table; reset discards every in-flight producer immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        ent_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        ent_q[r] <= ent_d[r];
      end
    end
  end

  logic unused_cls_none;
  assign unused_cls_none = ^CLS_NONE;
endmodule
